// File: rtl/delay_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the delay pipeline and its neighbours.
package delay_pipe_pkg;

   // Idle value for pixel-pipeline side-band registers.
   localparam int DEFAULT_RST_VAL = 0;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

   // A tap selects 0..d inclusive, so it needs to encode d+1 values.
   function automatic int tap_width(input int d);
      int r;
      r = clog2(d + 1);
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int clamp_tap(input int tap, input int d);
      return (tap > d) ? d : tap;
   endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One data+valid register of the delay pipe: async reset, synchronous flush, clock enable.
// One cycle per enabled edge; with ce low the stage holds its contents.
module delay_pipe_stage
   import delay_pipe_pkg::*;
#(
   parameter int W = 1,
   parameter logic [W-1:0] RST_VAL = W'(DEFAULT_RST_VAL)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         flush,
   input  logic [W-1:0] d,
   input  logic         d_vld,
   output logic [W-1:0] q,
   output logic         q_vld
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q     <= RST_VAL;
         q_vld <= 1'b0;
      end else if (flush) begin
         q     <= RST_VAL;
         q_vld <= 1'b0;
      end else if (ce) begin
         q     <= d;
         q_vld <= d_vld;
      end
   end

endmodule

// File: rtl/delay_pipe.sv
// W-bit, D-stage delay line with per-stage valid, clock enable, flush and a runtime output tap.
// Delay is min(tap,D) enabled edges; ce low stalls every stage without bubbles or drops.
module delay_pipe
   import delay_pipe_pkg::*;
#(
   parameter int W = 1,
   parameter int D = 4,
   parameter logic [W-1:0] RST_VAL = W'(DEFAULT_RST_VAL),
   localparam int TAP_W = tap_width(D)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             flush,
   input  logic [W-1:0]     i,
   input  logic             i_vld,
   input  logic [TAP_W-1:0] tap,
   output logic [W-1:0]     o,
   output logic             o_vld,
   output logic             primed
);

   generate
      if (D == 0) begin : g_bypass
         logic unused_ok;
         assign unused_ok = ^{clk, rst, ce, flush, tap};
         assign o      = i;
         assign o_vld  = i_vld;
         assign primed = 1'b1;
      end else begin : g_pipe
         localparam logic [TAP_W-1:0] D_MAX = TAP_W'(D);

         // Element 0 is the live input so tap 0 falls out of the same mux.
         logic [W-1:0]     dat [D+1];
         logic             vld [D+1];
         logic [TAP_W-1:0] cnt;
         logic [TAP_W-1:0] t;

         assign dat[0] = i;
         assign vld[0] = i_vld;

         for (genvar k = 0; k < D; k++) begin : g_stage
            delay_pipe_stage #(
               .W       (W),
               .RST_VAL (RST_VAL)
            ) u_stage (
               .clk   (clk),
               .rst   (rst),
               .ce    (ce),
               .flush (flush),
               .d     (dat[k]),
               .d_vld (vld[k]),
               .q     (dat[k+1]),
               .q_vld (vld[k+1])
            );
         end

         // Counts enabled shifts since reset/flush; saturates so it never wraps.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt <= '0;
            end else if (flush) begin
               cnt <= '0;
            end else if (ce && (cnt != D_MAX)) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign t      = TAP_W'(clamp_tap(int'(tap), D));
         assign o      = dat[t];
         assign o_vld  = vld[t];
         assign primed = (cnt >= t);
      end
   endgenerate

endmodule

// File: tb/tb_delay_pipe.sv
// Bench for delay_pipe: W=8/D=4 instance against a queue-based history model, plus a D=0 build.
module tb_delay_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ce = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_vld = 1'b0;
   logic [2:0] tap = 3'd4;

   logic [7:0] o;
   logic       o_vld;
   logic       primed;
   logic [7:0] oz;
   logic       oz_vld;
   logic       primed_z;

   int checks = 0;
   int errors = 0;

   // Model: newest-first history of {vld,dat} pushed on enabled edges, plus shift count.
   logic [8:0] hist[$];
   int         pushes;

   always #5 clk = ~clk;

   delay_pipe #(.W(8), .D(4), .RST_VAL(8'h00)) dut (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .flush  (flush),
      .i      (din),
      .i_vld  (din_vld),
      .tap    (tap),
      .o      (o),
      .o_vld  (o_vld),
      .primed (primed)
   );

   delay_pipe #(.W(8), .D(0), .RST_VAL(8'h00)) dut_z (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .flush  (flush),
      .i      (din),
      .i_vld  (din_vld),
      .tap    (tap[0]),
      .o      (oz),
      .o_vld  (oz_vld),
      .primed (primed_z)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < 4; k++) hist.push_back(9'h000);
      pushes = 0;
   endtask

   // Drive one cycle's inputs on the falling edge and compare outputs against the model.
   task automatic drive_chk(input logic c, input logic f, input logic [7:0] d,
                            input logic v, input logic [2:0] tp);
      int         t;
      logic [8:0] exp;
      @(negedge clk);
      ce = c;
      flush = f;
      din = d;
      din_vld = v;
      tap = tp;
      #1;
      t = (tp > 3'd4) ? 4 : int'(tp);
      exp = (t == 0) ? {v, d} : hist[t-1];
      check("o", 32'(o), 32'(exp[7:0]));
      check("o_vld", 32'(o_vld), 32'(exp[8]));
      check("primed", 32'(primed), 32'(pushes >= t));
      check("d0_o", 32'(oz), 32'(d));
      check("d0_vld", 32'(oz_vld), 32'(v));
      check("d0_primed", 32'(primed_z), 32'd1);
   endtask

   task automatic advance();
      @(posedge clk);
      if (flush) begin
         model_reset();
      end else if (ce) begin
         hist.push_front({din_vld, din});
         void'(hist.pop_back());
         pushes++;
      end
   endtask

   task automatic step(input logic c, input logic f, input logic [7:0] d,
                       input logic v, input logic [2:0] tp);
      drive_chk(c, f, d, v, tp);
      advance();
   endtask

   // Reset asserted between edges; outputs must settle before any clock edge.
   task automatic async_rst(input logic [2:0] tp);
      @(negedge clk);
      ce = 1'b0;
      flush = 1'b0;
      tap = tp;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_o", 32'(o), (tp == 3'd0) ? 32'(din) : 32'h00);
      check("rst_vld", 32'(o_vld), (tp == 3'd0) ? 32'(din_vld) : 32'd0);
      check("rst_primed", 32'(primed), (tp == 3'd0) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      check("rst_hold_vld", 32'(o_vld), (tp == 3'd0) ? 32'(din_vld) : 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Straight stream of 0x01.. with ce high and tap 4; first sample emerges on cycle 4.
   task automatic stream_check(input string tag);
      for (int n = 0; n < 8; n++) begin
         drive_chk(1'b1, 1'b0, 8'(n + 1), 1'b1, 3'd4);
         if (n == 3) check({tag, "_primed3"}, 32'(primed), 32'd0);
         if (n == 4) begin
            check({tag, "_o4"}, 32'(o), 32'h01);
            check({tag, "_vld4"}, 32'(o_vld), 32'd1);
            check({tag, "_primed4"}, 32'(primed), 32'd1);
         end
         advance();
      end
   endtask

   initial begin
      model_reset();

      async_rst(3'd0);
      async_rst(3'd4);
      stream_check("t1");

      // Stall on cycles 2-3: first sample arrives two cycles later, stream intact.
      async_rst(3'd4);
      begin
         int nxt = 1;
         for (int n = 0; n < 12; n++) begin
            logic c;
            c = !(n == 2 || n == 3);
            drive_chk(c, 1'b0, 8'(nxt), 1'b1, 3'd4);
            if (n == 5) check("t2_vld5", 32'(o_vld), 32'd0);
            if (n == 6) check("t2_o6", 32'(o), 32'h01);
            if (n == 9) check("t2_o9", 32'(o), 32'h04);
            advance();
            if (c) nxt++;
         end
      end

      // Tap 0 pass-through and clamping of tap 7 to 4.
      for (int n = 0; n < 6; n++) step(1'b1, 1'b0, 8'($urandom), 1'($urandom), 3'd0);
      for (int n = 0; n < 6; n++) step(1'b1, 1'b0, 8'(8'h40 + n), 1'b1, 3'd7);

      // Flush with ce on cycle 5; re-primes after four more enabled edges.
      async_rst(3'd4);
      for (int n = 0; n < 12; n++) begin
         drive_chk(1'b1, (n == 5), 8'(n + 1), 1'b1, 3'd4);
         if (n == 6) begin
            check("t4_o6", 32'(o), 32'h00);
            check("t4_vld6", 32'(o_vld), 32'd0);
            check("t4_primed6", 32'(primed), 32'd0);
         end
         if (n == 9) check("t4_primed9", 32'(primed), 32'd0);
         if (n == 10) check("t4_primed10", 32'(primed), 32'd1);
         advance();
      end

      // Reset mid-stream, then recovery matches a fresh start.
      for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 8'h99, 1'b1, 3'd4);
      async_rst(3'd4);
      stream_check("t5");

      // Tap switched 4->2->4 on a running stream.
      async_rst(3'd4);
      for (int n = 0; n < 10; n++) begin
         logic [2:0] tp;
         tp = (n == 6) ? 3'd2 : 3'd4;
         drive_chk(1'b1, 1'b0, 8'(n + 1), 1'b1, tp);
         if (n == 6) check("t6_tap2", 32'(o), 32'h05);
         if (n == 7) check("t6_tap4", 32'(o), 32'h04);
         advance();
      end

      // Random traffic with stalls, flushes, tap changes and occasional resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            async_rst(3'($urandom_range(0, 7)));
         end else begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
                 8'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
